// File: rtl/huc6260_vce_if.sv
// CPU register bus of the HuC6260 colour encoder: address, data and active-low strobes.
interface huc6260_vce_if;
  logic [2:0] A;
  logic [7:0] D_in;
  logic [7:0] D_out;
  logic       CS_n;
  logic       WR_n;
  logic       RD_n;

  modport master (output A, D_in, CS_n, WR_n, RD_n, input D_out);
  modport slave  (input A, D_in, CS_n, WR_n, RD_n, output D_out);
endinterface

// File: rtl/huc6260_vce.sv
// HuC6260 video colour encoder: 512x9 GRB palette loaded over the CPU bus,
// registered pixel lookup with sync blanking, and the VDC dot-clock enable.
module huc6260_vce #(
  parameter int PAL_WORDS = 512
) (
  input  logic       clock,
  input  logic       reset,
  huc6260_vce_if.slave bus,
  input  logic [8:0] VD,
  input  logic       HSYN,
  input  logic       VSYN,
  output logic [2:0] VIDEO_R,
  output logic [2:0] VIDEO_G,
  output logic [2:0] VIDEO_B,
  output logic       CK,
  output logic [1:0] address_mode
);

  logic [1:0] cr, div, div_last;
  logic [8:0] cta, idx, pix;
  logic       wr_hist, rd_hist, armed;
  logic       sel, wr_stb, rd_stb, cr_wr;

  // Palette has no reset; its contents survive a reset and power up zero.
  logic [8:0] pal [PAL_WORDS];

  assign sel = !bus.CS_n;
  // armed keeps a strobe that was already low through reset from committing:
  // a fresh high-to-low transition must be seen after release.
  assign wr_stb = sel && !bus.WR_n && wr_hist && armed;
  assign rd_stb = sel && !bus.RD_n && rd_hist && armed && bus.WR_n;
  assign cr_wr  = wr_stb && (bus.A == 3'd0);

  assign address_mode = cr;

  always_comb begin
    bus.D_out = '0;
    if (!reset && sel && !bus.RD_n) begin
      case (bus.A)
        3'd4:    bus.D_out = pal[cta][7:0];
        3'd5:    bus.D_out = {7'h7F, pal[cta][8]};
        default: bus.D_out = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cr      <= '0;
      cta     <= '0;
      wr_hist <= 1'b1;
      rd_hist <= 1'b1;
      armed   <= 1'b0;
    end else begin
      wr_hist <= bus.WR_n;
      rd_hist <= bus.RD_n;
      armed   <= 1'b1;
      if (wr_stb) begin
        case (bus.A)
          3'd0:    cr       <= bus.D_in[1:0];
          3'd2:    cta[7:0] <= bus.D_in;
          3'd3:    cta[8]   <= bus.D_in[0];
          3'd5:    cta      <= cta + 9'd1;
          default: ;
        endcase
      end else if (rd_stb && bus.A == 3'd5) begin
        cta <= cta + 9'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_stb && bus.A == 3'd4) pal[cta][7:0] <= bus.D_in;
    if (wr_stb && bus.A == 3'd5) pal[cta][8]   <= bus.D_in[0];
  end

  // Divide by 4 / 3 / 2; a CR write restarts the phase.
  always_comb begin
    case (cr)
      2'd0:    div_last = 2'd3;
      2'd1:    div_last = 2'd2;
      default: div_last = 2'd1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div <= '0;
      CK  <= 1'b0;
    end else if (cr_wr) begin
      div <= '0;
      CK  <= 1'b0;
    end else if (div >= div_last) begin
      div <= '0;
      CK  <= 1'b1;
    end else begin
      div <= div + 2'd1;
      CK  <= 1'b0;
    end
  end

  // Colour 0 of every background palette collapses onto entry 0.
  assign idx = (!VD[8] && VD[3:0] == 4'd0) ? 9'h000 : VD;
  assign pix = pal[idx];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      VIDEO_R <= '0;
      VIDEO_G <= '0;
      VIDEO_B <= '0;
    end else if (!HSYN || !VSYN) begin
      VIDEO_R <= '0;
      VIDEO_G <= '0;
      VIDEO_B <= '0;
    end else begin
      VIDEO_G <= pix[8:6];
      VIDEO_R <= pix[5:3];
      VIDEO_B <= pix[2:0];
    end
  end

endmodule

// File: tb/tb_huc6260_vce.sv
// Randomised scoreboard bench for huc6260_vce against a register-level palette model.
module tb_huc6260_vce;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [8:0] VD = 9'h055;
  logic       HSYN = 1'b1, VSYN = 1'b1;
  logic [2:0] VIDEO_R, VIDEO_G, VIDEO_B;
  logic       CK;
  logic [1:0] address_mode;

  huc6260_vce_if bus ();

  huc6260_vce #(.PAL_WORDS(512)) dut (
    .clock(clock), .reset(reset), .bus(bus), .VD(VD), .HSYN(HSYN), .VSYN(VSYN),
    .VIDEO_R(VIDEO_R), .VIDEO_G(VIDEO_G), .VIDEO_B(VIDEO_B),
    .CK(CK), .address_mode(address_mode)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] r, g, b;
    logic       ck;
    logic [1:0] am;
  } exp_t;

  exp_t       q[$];
  int         checks = 0, errors = 0;
  logic [8:0] pal_m [512];
  logic [1:0] cr_m = 0;
  logic [8:0] cta_m = 0;
  int         ticks = 0;
  logic       wr_seen = 0, rd_seen = 0;
  logic       rand_px = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int period(input logic [1:0] c);
    return (c == 2'd0) ? 4 : (c == 2'd1) ? 3 : 2;
  endfunction

  function automatic logic [7:0] dexp(input logic [2:0] a);
    if (a == 3'd4) return pal_m[cta_m][7:0];
    if (a == 3'd5) return {7'h7F, pal_m[cta_m][8]};
    return 8'hFF;
  endfunction

  // Reference: what one clock edge does to palette, pointer, CR and the outputs.
  task automatic model_step();
    exp_t e;
    logic [8:0] ix, w;
    logic wc, rc;
    e = '0;
    if (reset) begin
      cr_m = 0; cta_m = 0; ticks = 0; wr_seen = 0; rd_seen = 0;
    end else begin
      ix = (!VD[8] && VD[3:0] == 4'd0) ? 9'h000 : VD;
      w  = pal_m[ix];
      if (HSYN && VSYN) begin e.g = w[8:6]; e.r = w[5:3]; e.b = w[2:0]; end
      wc = !bus.CS_n && !bus.WR_n && wr_seen;
      rc = !bus.CS_n && !bus.RD_n && rd_seen && bus.WR_n;
      if (wc && bus.A == 3'd0) ticks = 0;
      else begin
        ticks++;
        e.ck = ((ticks % period(cr_m)) == 0);
      end
      if (wc) begin
        case (bus.A)
          3'd0: cr_m = bus.D_in[1:0];
          3'd2: cta_m[7:0] = bus.D_in;
          3'd3: cta_m[8] = bus.D_in[0];
          3'd4: pal_m[cta_m][7:0] = bus.D_in;
          3'd5: begin pal_m[cta_m][8] = bus.D_in[0]; cta_m = cta_m + 9'd1; end
          default: ;
        endcase
      end else if (rc && bus.A == 3'd5) cta_m = cta_m + 9'd1;
      wr_seen = bus.WR_n;
      rd_seen = bus.RD_n;
      e.am = cr_m;
    end
    q.push_back(e);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) pal_m[i] = '0;
    forever begin
      @(posedge clock);
      model_step();
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() != 0) begin
        e = q.pop_front();
        if (reset) e = '0;
        chk("video_out", {VIDEO_R, VIDEO_G, VIDEO_B, CK, address_mode}, e);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    if (rand_px) begin
      VD   = 9'($urandom);
      HSYN = ($urandom_range(0, 7) != 0);
      VSYN = ($urandom_range(0, 7) != 0);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus.A = a; bus.D_in = d; bus.CS_n = 0; bus.WR_n = 0;
    tick();
    bus.WR_n = 1; bus.CS_n = 1;
    tick();
  endtask

  task automatic rd(input logic [2:0] a, input string nm);
    bus.A = a; bus.CS_n = 0; bus.RD_n = 0;
    #1;
    chk(nm, bus.D_out, dexp(a));
    tick();
    bus.RD_n = 1; bus.CS_n = 1;
    tick();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    bus.A = 0; bus.D_in = 0; bus.CS_n = 1; bus.WR_n = 1; bus.RD_n = 1;
    #1 reset = 1;
    bus.CS_n = 0; bus.RD_n = 0; bus.A = 3'd4;
    #1 chk("reset_dout", bus.D_out, 0);
    chk("reset_ck", CK, 0);
    chk("reset_rgb", {VIDEO_R, VIDEO_G, VIDEO_B}, 0);
    bus.CS_n = 1; bus.RD_n = 1;
    run(3);
    reset = 0;
    run(3);

    // Load entry 0x010 then look at BG colour-0 mapping and neighbours.
    wr(3'd2, 8'h10); wr(3'd3, 8'h00); wr(3'd4, 8'hC7); wr(3'd5, 8'h01);
    VD = 9'h010; run(3);
    VD = 9'h011; run(3);
    VD = 9'h110; run(3);

    wr(3'd2, 8'h10); wr(3'd3, 8'h00);
    rd(3'd4, "rd_lo_010");
    rd(3'd5, "rd_hi_010");
    rd(3'd4, "rd_lo_011");
    bus.A = 3'd1; bus.CS_n = 0; bus.RD_n = 0; #1 chk("rd_unmapped", bus.D_out, 8'hFF);
    bus.RD_n = 1; bus.CS_n = 1; #1 chk("dout_idle", bus.D_out, 0);
    tick();

    // Last entry, pointer wrap.
    wr(3'd2, 8'hFF); wr(3'd3, 8'h01); wr(3'd4, 8'h38); wr(3'd5, 8'h01);
    rd(3'd4, "cta_wrap_rd");
    VD = 9'h1FF; run(2);
    chk("g_1ff", VIDEO_G, 4); chk("r_1ff", VIDEO_R, 7); chk("b_1ff", VIDEO_B, 0);
    VSYN = 0; run(3); VSYN = 1; run(3);
    HSYN = 0; run(2); HSYN = 1; run(2);

    // Dot clock for each CR setting.
    wr(3'd0, 8'h00); run(12);
    wr(3'd0, 8'h01); run(12);
    chk("address_mode_1", address_mode, 1);
    wr(3'd0, 8'h02); run(8);
    wr(3'd0, 8'hFF); run(8);
    wr(3'd0, 8'h00); run(4);

    // Held write strobe commits once.
    wr(3'd2, 8'h21); wr(3'd3, 8'h00); wr(3'd4, 8'h5A);
    wr(3'd2, 8'h20);
    bus.A = 3'd5; bus.D_in = 8'h01; bus.CS_n = 0; bus.WR_n = 0;
    run(10);
    bus.WR_n = 1; bus.CS_n = 1; tick();
    bus.A = 3'd4; bus.CS_n = 0; bus.RD_n = 0; #1 chk("held_wr_once", bus.D_out, 8'h5A);
    bus.RD_n = 1; bus.CS_n = 1; tick();

    // Simultaneous read/write strobes: write only, single increment.
    wr(3'd2, 8'h31); wr(3'd4, 8'h77); wr(3'd2, 8'h30);
    bus.A = 3'd5; bus.D_in = 8'h00; bus.CS_n = 0; bus.WR_n = 0; bus.RD_n = 0;
    tick();
    bus.WR_n = 1; bus.RD_n = 1; bus.CS_n = 1; tick();
    bus.A = 3'd4; bus.CS_n = 0; bus.RD_n = 0; #1 chk("rdwr_one_inc", bus.D_out, 8'h77);
    bus.RD_n = 1; bus.CS_n = 1; tick();

    // Strobe low across reset must not commit afterwards.
    bus.A = 3'd4; bus.D_in = 8'hEE; bus.CS_n = 0; bus.WR_n = 0; reset = 1;
    run(2);
    reset = 0;
    run(3);
    bus.WR_n = 1; bus.RD_n = 0; #1 chk("reset_drop_wr", bus.D_out, 8'h00);
    bus.RD_n = 1; bus.CS_n = 1; tick();

    // Randomised traffic.
    rand_px = 1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0: wr(3'd0, 8'($urandom));
        1: wr(3'd2, 8'($urandom));
        2: wr(3'd3, 8'($urandom));
        3, 4: wr(3'd4, 8'($urandom));
        5: wr(3'd5, 8'($urandom));
        6: rd(3'd4, "rand_rd_lo");
        7: rd(3'd5, "rand_rd_hi");
        8: rd(3'($urandom_range(6, 7)), "rand_rd_ff");
        default: run($urandom_range(1, 4));
      endcase
    end
    rand_px = 0;
    run(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
